// File: rtl/router_vc_output_port.sv
// Router output port with NUM_VC virtual-channel FIFOs and a round-robin link arbiter.
// Each output flit is registered, and a flit never bypasses its FIFO.
module router_vc_output_port #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned VC_DEPTH = 2,
    localparam int unsigned VC_W    = $clog2(NUM_VC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [NUM_VC-1:0] blocked,
    input  logic [NUM_VC-1:0] out_ready,
    output logic              out_send,
    output logic [VC_W-1:0]   out_vc,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(VC_DEPTH + 1);

    logic [DATA_W-1:0] mem    [NUM_VC][VC_DEPTH];
    logic [CNT_W-1:0]  count  [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [VC_W-1:0]   rr_ptr;

    logic [NUM_VC-1:0] enq_vec;
    logic [NUM_VC-1:0] deq_vec;
    logic              win_found;
    logic [VC_W-1:0]   win_vc;
    logic [VC_W-1:0]   scan_vc;
    logic [VC_W-1:0]   rr_next;

    // Pointers wrap explicitly so VC_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        blocked = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            blocked[v] = (count[v] == CNT_W'(VC_DEPTH));
        end
    end

    // An out-of-range in_vc matches no VC, leaving in_ready low.
    always_comb begin
        in_ready = 1'b0;
        enq_vec  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_vc == VC_W'(v)) begin
                in_ready   = !blocked[v];
                enq_vec[v] = in_valid && !blocked[v];
            end
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_vc    = '0;
        scan_vc   = '0;
        deq_vec   = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            scan_vc = VC_W'((32'(rr_ptr) + i) % NUM_VC);
            if (!win_found && count[scan_vc] != '0 && out_ready[scan_vc]) begin
                win_found = 1'b1;
                win_vc    = scan_vc;
            end
        end
        if (win_found) begin
            deq_vec[win_vc] = 1'b1;
        end
        rr_next = (win_vc == VC_W'(NUM_VC - 1)) ? '0 : win_vc + VC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            out_send <= 1'b0;
            out_vc   <= '0;
            out_data <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                count[v]  <= '0;
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
            end
        end else begin
            out_send <= win_found;
            out_vc   <= win_found ? win_vc : '0;
            out_data <= win_found ? mem[win_vc][rd_ptr[win_vc]] : '0;
            if (win_found) begin
                rr_ptr <= rr_next;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (enq_vec[v]) begin
                    wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                end
                if (deq_vec[v]) begin
                    rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                end
                if (enq_vec[v] && !deq_vec[v]) begin
                    count[v] <= count[v] + CNT_W'(1);
                end else if (deq_vec[v] && !enq_vec[v]) begin
                    count[v] <= count[v] - CNT_W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (enq_vec[v]) begin
                mem[v][wr_ptr[v]] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_router_vc_output_port.sv
// Bench for router_vc_output_port: a 2x2 and a 4x3 instance, each checked every cycle
// against a queue-based reference model, plus directed scenarios with literal expectations.
module tb_router_vc_output_port;

    bit   clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Stimulus per instance: index 0 = 2 VCs x depth 2, index 1 = 4 VCs x depth 3.
    bit          s_valid [2];
    int          s_vc    [2];
    logic [63:0] s_data  [2];
    int          s_ready [2];

    logic        a_in_valid, a_in_ready, a_out_send;
    logic [0:0]  a_in_vc, a_out_vc;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_blocked, a_out_ready;

    logic        b_in_valid, b_in_ready, b_out_send;
    logic [1:0]  b_in_vc, b_out_vc;
    logic [15:0] b_in_data, b_out_data;
    logic [3:0]  b_blocked, b_out_ready;

    assign a_in_valid  = s_valid[0];
    assign a_in_vc     = 1'(s_vc[0]);
    assign a_in_data   = s_data[0];
    assign a_out_ready = 2'(s_ready[0]);
    assign b_in_valid  = s_valid[1];
    assign b_in_vc     = 2'(s_vc[1]);
    assign b_in_data   = s_data[1][15:0];
    assign b_out_ready = 4'(s_ready[1]);

    router_vc_output_port #(.DATA_W(64), .NUM_VC(2), .VC_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_vc(a_in_vc), .in_data(a_in_data), .in_ready(a_in_ready),
        .blocked(a_blocked), .out_ready(a_out_ready),
        .out_send(a_out_send), .out_vc(a_out_vc), .out_data(a_out_data)
    );

    router_vc_output_port #(.DATA_W(16), .NUM_VC(4), .VC_DEPTH(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_vc(b_in_vc), .in_data(b_in_data), .in_ready(b_in_ready),
        .blocked(b_blocked), .out_ready(b_out_ready),
        .out_send(b_out_send), .out_vc(b_out_vc), .out_data(b_out_data)
    );

    // Reference model: one queue per VC, expected registered outputs, round-robin start.
    logic [63:0] mq [2][4][$];
    int          nvc [2] = '{2, 4};
    int          dep [2] = '{2, 3};
    int          rr [2];
    bit          e_send [2];
    int          e_vc [2];
    logic [63:0] e_data [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic int exp_blocked(int k);
        int m = 0;
        for (int v = 0; v < nvc[k]; v++) begin
            if (mq[k][v].size() == dep[k]) m |= (1 << v);
        end
        return m;
    endfunction

    function automatic bit exp_ready(int k);
        if (s_vc[k] < 0 || s_vc[k] >= nvc[k]) return 1'b0;
        return mq[k][s_vc[k]].size() < dep[k];
    endfunction

    function automatic void model_step(int k);
        bit acc;
        int w = -1;
        if (reset) begin
            for (int v = 0; v < 4; v++) mq[k][v].delete();
            rr[k] = 0; e_send[k] = 1'b0; e_vc[k] = 0; e_data[k] = '0;
            return;
        end
        acc = s_valid[k] && exp_ready(k);
        for (int i = 0; i < nvc[k]; i++) begin
            int v = (rr[k] + i) % nvc[k];
            if (w < 0 && mq[k][v].size() > 0 && ((s_ready[k] >> v) & 1) == 1) w = v;
        end
        if (w >= 0) begin
            e_send[k] = 1'b1;
            e_vc[k]   = w;
            e_data[k] = mq[k][w].pop_front();
            rr[k]     = (w + 1) % nvc[k];
        end else begin
            e_send[k] = 1'b0; e_vc[k] = 0; e_data[k] = '0;
        end
        if (acc) mq[k][s_vc[k]].push_back(s_data[k]);
    endfunction

    function automatic void compare_all();
        chk("a_out_send", 64'(a_out_send), 64'(e_send[0]));
        chk("a_out_vc",   64'(a_out_vc),   64'(e_vc[0]));
        chk("a_out_data", a_out_data,      e_data[0]);
        chk("a_blocked",  64'(a_blocked),  64'(exp_blocked(0)));
        chk("a_in_ready", 64'(a_in_ready), 64'(exp_ready(0)));
        chk("b_out_send", 64'(b_out_send), 64'(e_send[1]));
        chk("b_out_vc",   64'(b_out_vc),   64'(e_vc[1]));
        chk("b_out_data", 64'(b_out_data), e_data[1]);
        chk("b_blocked",  64'(b_blocked),  64'(exp_blocked(1)));
        chk("b_in_ready", 64'(b_in_ready), 64'(exp_ready(1)));
    endfunction

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic cycle();
        #1;
        if (cmp_en) compare_all();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(bit v, int vc, logic [63:0] d, int r);
        s_valid[0] = v; s_vc[0] = vc; s_data[0] = d; s_ready[0] = r;
    endtask

    int t4_vc   [4] = '{0, 1, 0, 1};
    int t4_data [4] = '{1, 3, 2, 4};
    int t4_in_vc[4] = '{0, 0, 1, 1};

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; s_vc[k] = 0; s_data[k] = '0; s_ready[k] = 0;
        end
        @(negedge clk);
        cycle();
        cmp_en = 1'b1;
        cycle();
        reset = 1'b0;

        // Idle after reset
        repeat (3) cycle();
        chk("t1_send", 64'(a_out_send), 64'd0);
        chk("t1_data", a_out_data, 64'd0);
        chk("t1_blocked", 64'(a_blocked), 64'd0);
        s_vc[0] = 0;
        #1 chk("t1_in_ready", 64'(a_in_ready), 64'd1);

        // Zero payload is a real flit
        set_a(1, 1, 64'h0, 3);
        cycle();
        set_a(0, 0, 64'h0, 3);
        cycle();
        chk("t2_send", 64'(a_out_send), 64'd1);
        chk("t2_vc", 64'(a_out_vc), 64'd1);
        chk("t2_data", a_out_data, 64'd0);
        cycle();

        // Fill VC0 with downstream stalled, third write dropped
        set_a(1, 0, 64'hA, 0); cycle();
        set_a(1, 0, 64'hB, 0); cycle();
        set_a(1, 0, 64'hC, 0);
        #1;
        chk("t3_in_ready", 64'(a_in_ready), 64'd0);
        chk("t3_blocked", 64'(a_blocked), 64'd1);
        cycle();
        set_a(0, 0, 64'h0, 1);
        cycle();
        chk("t3_send_a", 64'(a_out_send), 64'd1);
        chk("t3_data_a", a_out_data, 64'hA);
        cycle();
        chk("t3_data_b", a_out_data, 64'hB);
        cycle();
        chk("t3_no_c", 64'(a_out_send), 64'd0);

        // Round-robin alternation from a fresh reset
        reset = 1'b1; set_a(0, 0, 64'h0, 0); cycle(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_a(1, t4_in_vc[i], 64'(t4_data[i == 1 ? 1 : (i == 2 ? 2 : i)] * 0 + i + 1), 0);
            cycle();
        end
        set_a(0, 0, 64'h0, 3);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_vc", 64'(a_out_vc), 64'(t4_vc[i]));
            chk("t4_data", a_out_data, 64'(t4_data[i]));
        end

        // Dequeue on a full VC does not free space in the same cycle
        set_a(1, 0, 64'h55, 0); cycle();
        set_a(1, 0, 64'h66, 0); cycle();
        set_a(1, 0, 64'h77, 1);
        #1 chk("t5_in_ready", 64'(a_in_ready), 64'd0);
        cycle();
        set_a(0, 0, 64'h0, 1);
        chk("t5_blocked", 64'(a_blocked), 64'd0);
        chk("t5_data_55", a_out_data, 64'h55);
        cycle();
        chk("t5_data_66", a_out_data, 64'h66);
        cycle();
        chk("t5_no_77", 64'(a_out_send), 64'd0);

        // Reset while sending discards stored flits
        set_a(1, 1, 64'h91, 0); cycle();
        set_a(1, 1, 64'h92, 0); cycle();
        chk("t6_blocked_full", 64'(a_blocked), 64'd2);
        set_a(0, 0, 64'h0, 2);
        cycle();
        chk("t6_data_91", a_out_data, 64'h91);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_send_rst", 64'(a_out_send), 64'd0);
        chk("t6_blocked_rst", 64'(a_blocked), 64'd0);
        set_a(0, 0, 64'h0, 3);
        repeat (4) cycle();
        chk("t6_no_stale", 64'(a_out_send), 64'd0);

        // Depth-3 pointer wrap: 7 writes and 7 reads on one VC
        s_valid[1] = 1'b1; s_vc[1] = 2; s_ready[1] = 4;
        for (int i = 0; i < 7; i++) begin
            s_data[1] = 64'(i + 1);
            cycle();
        end
        s_valid[1] = 1'b0;
        cycle();
        chk("t6b_vc", 64'(b_out_vc), 64'd2);
        chk("t6b_data", 64'(b_out_data), 64'd7);
        cycle();

        // Randomized traffic on both instances with occasional reset
        repeat (4000) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = ($urandom_range(0, 9) < 7);
                s_vc[k]    = $urandom_range(0, nvc[k] - 1);
                s_data[k]  = (k == 1) ? 64'($urandom_range(0, 65535)) : {$urandom, $urandom};
                s_ready[k] = $urandom_range(0, (1 << nvc[k]) - 1);
            end
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
